// File: rtl/op_sequencer.sv
// op_sequencer: buffers host commands in a FIFO and issues them one at a time to the FHE controller.
// Optional hung-operation watchdog is compiled in when OP_SEQ_TIMEOUT_EN is defined.
module op_sequencer #(
  parameter int ADDR_WIDTH     = 10,
  parameter int DEPTH          = 4,
  parameter int DEPTH_WIDTH    = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TIMEOUT_WIDTH  = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_opcode,
  input  logic [ADDR_WIDTH-1:0] cmd_op1_addr,
  input  logic [ADDR_WIDTH-1:0] cmd_op2_addr,
  input  logic [ADDR_WIDTH-1:0] cmd_out_addr,
  input  logic                  ctrl_en,
  input  logic                  ctrl_done,
  output logic                  config_en,
  output logic [1:0]            opcode,
  output logic [ADDR_WIDTH-1:0] op1_base_addr,
  output logic [ADDR_WIDTH-1:0] op2_base_addr,
  output logic [ADDR_WIDTH-1:0] out_base_addr,
  output logic                  busy,
  output logic                  cmpl_valid,
  output logic [1:0]            cmpl_opcode,
  output logic [7:0]            cmpl_count,
  input  logic                  err_clr,
  output logic                  error
);

  typedef enum logic [2:0] {IDLE, ISSUE, SETTLE, WAIT, HALT} state_t;

  state_t state, next_state;

  logic [1:0]            op_mem  [DEPTH];
  logic [ADDR_WIDTH-1:0] op1_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] op2_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] out_mem [DEPTH];

  logic [DEPTH_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_WIDTH:0]   count, count_next;
  logic full, empty, push, pop, complete, timeout, clr;
  logic config_en_d, busy_d;

  assign full      = (count == (DEPTH_WIDTH+1)'(DEPTH));
  assign empty     = (count == '0);
  assign cmd_ready = rst_n && !full;
  assign push      = cmd_valid && cmd_ready;
  assign complete  = (state == WAIT) && ctrl_done && !ctrl_en;
  assign pop       = (next_state == ISSUE);

`ifdef OP_SEQ_TIMEOUT_EN
  logic [TIMEOUT_WIDTH-1:0] wd_cnt;

  // Counter is zero on the first WAIT cycle, so the limit trips on the last allowed WAIT cycle.
  assign timeout = (state == WAIT) && !complete &&
                   (wd_cnt == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1));
  assign clr     = err_clr;

  always_ff @(posedge clk) begin
    if (!rst_n)              wd_cnt <= '0;
    else if (state != WAIT)  wd_cnt <= '0;
    else                     wd_cnt <= wd_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                        error <= 1'b0;
    else if (timeout)                  error <= 1'b1;
    else if (state == HALT && err_clr) error <= 1'b0;
  end
`else
  logic                     unused_err_clr;
  logic [TIMEOUT_WIDTH-1:0] unused_timeout;

  assign unused_err_clr = err_clr;
  assign unused_timeout = TIMEOUT_WIDTH'(TIMEOUT_CYCLES);
  assign timeout        = 1'b0;
  assign clr            = 1'b0;
  assign error          = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // SETTLE deliberately ignores ctrl_*: done is still left over from the previous operation.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (!empty) next_state = ISSUE;
      ISSUE:   next_state = SETTLE;
      SETTLE:  next_state = WAIT;
      WAIT: begin
        if (complete)     next_state = empty ? IDLE : ISSUE;
        else if (timeout) next_state = HALT;
      end
      HALT:    if (clr) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + 1'b1;
    else if (pop && !push) count_next = count - 1'b1;
  end

  always_comb begin
    config_en_d = (next_state == ISSUE);
    busy_d      = (next_state != IDLE) || (count_next != '0);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      op_mem[wr_ptr]  <= cmd_opcode;
      op1_mem[wr_ptr] <= cmd_op1_addr;
      op2_mem[wr_ptr] <= cmd_op2_addr;
      out_mem[wr_ptr] <= cmd_out_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      config_en     <= 1'b0;
      busy          <= 1'b0;
      opcode        <= '0;
      op1_base_addr <= '0;
      op2_base_addr <= '0;
      out_base_addr <= '0;
    end else begin
      config_en <= config_en_d;
      busy      <= busy_d;
      if (pop) begin
        opcode        <= op_mem[rd_ptr];
        op1_base_addr <= op1_mem[rd_ptr];
        op2_base_addr <= op2_mem[rd_ptr];
        out_base_addr <= out_mem[rd_ptr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmpl_valid  <= 1'b0;
      cmpl_opcode <= '0;
      cmpl_count  <= '0;
    end else begin
      cmpl_valid <= complete;
      if (complete) begin
        cmpl_opcode <= opcode;
        cmpl_count  <= cmpl_count + 8'd1;
      end
    end
  end

endmodule
